// File: rtl/module_uart_engine.sv
// -----------------------------------------------------------------------------
// module_uart_engine
//
// UART-side engine behind a two-register UART block:
//   reg0 = control/status, reg1 = data.
//
// The engine reads the current register contents on ctrl_i and data_i.
// It serialises the TX byte onto tx_o and deserialises rx_i into a byte.
// It returns results through its own write ports:
//   - clears SEND after a TX frame,
//   - sets NEW_RX or FERR after an RX frame,
//   - writes the received byte into reg1.
// The bus side sets SEND and clears NEW_RX/FERR. This block never drives them.
//
// Framing is 8N1, LSB first.
//
// Ports
//   clk_i      in   1   single clock
//   rst_i      in   1   synchronous, active-low reset
//   ctrl_i     in   32  reg0: [0]=SEND, [1]=NEW_RX, [2]=FERR, [31:3] bus-owned
//   data_i     in   32  reg1: [DATA_BITS-1:0] = TX byte
//   rx_i       in   1   serial input, asynchronous, idle high
//   tx_o       out  1   serial output, idle high
//   wr_ctrl_o  out  1   one-cycle write strobe for reg0
//   ctrl_o     out  32  reg0 write value (0 when wr_ctrl_o is 0)
//   wr_data_o  out  1   one-cycle write strobe for reg1
//   data_o     out  32  reg1 write value (0 when wr_data_o is 0)
// -----------------------------------------------------------------------------
module module_uart_engine #(
  parameter int BAUD_DIV  = 1042,
  parameter int DATA_BITS = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] ctrl_i,
  input  logic [31:0] data_i,
  input  logic        rx_i,
  output logic        tx_o,
  output logic        wr_ctrl_o,
  output logic [31:0] ctrl_o,
  output logic        wr_data_o,
  output logic [31:0] data_o
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_DONE
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  // TX datapath
  tx_state_t            tx_state_q, tx_state_d;
  logic [CW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [BW-1:0]        tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d;
  logic                 tx_line_q, tx_line_d;
  logic                 tx_tick;
  logic                 tx_done;

  // RX datapath
  rx_state_t            rx_state_q, rx_state_d;
  logic [CW-1:0]        rx_cnt_q, rx_cnt_d;
  logic [BW-1:0]        rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] rx_sh_q, rx_sh_d;
  logic [1:0]           rx_sync_q;
  logic                 rx_s;
  logic                 rx_tick;
  logic                 rx_done;
  logic                 rx_ferr;

  // Only the low DATA_BITS of reg1 feed the transmitter.
  logic unused_data_hi;
  assign unused_data_hi = ^data_i[31:DATA_BITS];

  assign tx_tick = (tx_cnt_q == CNT_LAST);
  assign rx_tick = (rx_cnt_q == CNT_LAST);
  assign rx_s    = rx_sync_q[1];

  // ---------------------------------------------------------------------------
  // Sequential state
  // ---------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, whatever the statement order.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      tx_line_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      rx_sync_q  <= 2'b11;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      rx_sync_q  <= {rx_sync_q[0], rx_i};
    end
  end

  // ---------------------------------------------------------------------------
  // TX next-state
  // ---------------------------------------------------------------------------
  // NOTE: every signal gets a default before the case statement. This keeps
  // the block free of inferred latches even when a branch skips an assignment.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + CW'(1);
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_done    = 1'b0;

    unique case (tx_state_q)
      TX_IDLE: begin
        tx_cnt_d = '0;
        // The byte is captured here. Later writes to reg1 cannot disturb the
        // frame in flight.
        if (ctrl_i[0]) begin
          tx_sh_d    = data_i[DATA_BITS-1:0];
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_tick) begin
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_tick) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bit_q == BIT_LAST) begin
            tx_state_d = TX_STOP;
          end else begin
            tx_bit_d = tx_bit_q + BW'(1);
          end
        end
      end
      TX_STOP: begin
        if (tx_tick) begin
          tx_state_d = TX_DONE;
        end
      end
      TX_DONE: begin
        // SEND is cleared by this cycle's write. The cleared value is back on
        // ctrl_i by the time IDLE samples it again.
        tx_done    = 1'b1;
        tx_cnt_d   = '0;
        tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // The line level is decoded from the next state and then registered. This
    // keeps tx_o glitch-free and aligned with tx_state_q.
    tx_line_d = 1'b1;
    if (tx_state_d == TX_START) begin
      tx_line_d = 1'b0;
    end else if (tx_state_d == TX_DATA) begin
      tx_line_d = tx_sh_d[0];
    end
  end

  assign tx_o = tx_line_q;

  // ---------------------------------------------------------------------------
  // RX next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_tick ? '0 : rx_cnt_q + CW'(1);
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_done    = 1'b0;
    rx_ferr    = 1'b0;

    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_s) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        // Re-check the start bit at mid-bit. A line already high again is
        // treated as a glitch and produces no write.
        if (rx_cnt_q == CNT_HALF) begin
          rx_cnt_d = '0;
          if (rx_s) begin
            rx_state_d = RX_IDLE;
          end else begin
            rx_bit_d   = '0;
            rx_state_d = RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_sh_d = {rx_s, rx_sh_q[DATA_BITS-1:1]};
          if (rx_bit_q == BIT_LAST) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + BW'(1);
          end
        end
      end
      RX_STOP: begin
        // Returning to IDLE in the sampling cycle lets a start bit that
        // follows immediately be accepted.
        if (rx_tick) begin
          rx_state_d = RX_IDLE;
          if (rx_s) begin
            rx_done = 1'b1;
          end else begin
            rx_ferr = 1'b1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register write-back
  // ---------------------------------------------------------------------------
  // TX and RX completions in the same cycle merge into one reg0 write. This
  // way neither update overwrites the other.
  assign wr_ctrl_o = tx_done | rx_done | rx_ferr;
  assign wr_data_o = rx_done;

  always_comb begin
    ctrl_o = '0;
    if (wr_ctrl_o) begin
      ctrl_o[31:3] = ctrl_i[31:3];
      ctrl_o[2]    = rx_ferr | ctrl_i[2];
      ctrl_o[1]    = rx_done | ctrl_i[1];
      ctrl_o[0]    = ctrl_i[0] & ~tx_done;
    end
  end

  // A new byte is written even if NEW_RX is still set; there is no overrun flag.
  always_comb begin
    data_o = '0;
    if (rx_done) begin
      data_o[DATA_BITS-1:0] = rx_sh_q;
    end
  end

endmodule
